// File: rtl/e1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e1_pkg
// Brief    : Shared E1 CRC4 constants and multiframe position markers.
// Revision : 1.0 - initial release
// ============================================================================
package e1_pkg;

    // CRC4 generator x^4 + x + 1, serial MSB first, zero preset
    localparam logic [3:0] c_CRC4_POLY      = 4'h3;
    localparam logic [3:0] c_CRC4_INIT      = 4'h0;

    localparam logic [4:0] c_TS0            = 5'd0;
    localparam logic [4:0] c_TS_LAST        = 5'd31;
    localparam logic [2:0] c_BIT_FIRST      = 3'd0;
    localparam logic [2:0] c_BIT_LAST       = 3'd7;
    localparam int         c_SMF_FRAMES     = 8;
    localparam logic [2:0] c_SMF_LAST_FRAME = 3'(c_SMF_FRAMES - 1);

    // Bit-stream position tag as delivered by the framer
    typedef struct packed {
        logic [3:0] frame;
        logic [4:0] ts;
        logic [2:0] bit_pos;
    } e1_pos_t;

endpackage : e1_pkg
`default_nettype wire

// File: rtl/e1_crc4.sv
`default_nettype none
// ============================================================================
// Module   : e1_crc4
// Brief    : Serial CRC4 engine; i_first restarts the remainder from INIT.
// Revision : 1.0 - initial release
// ============================================================================
module e1_crc4 #(
    parameter logic [3:0] INIT = 4'h0,
    parameter logic [3:0] POLY = 4'h3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_first,
    input  logic       i_bit,
    output logic [3:0] o_crc
);

    logic [3:0] r_crc;
    logic [3:0] w_base;
    logic [3:0] w_next;
    logic       w_fb;

    always_comb begin
        w_base = i_first ? INIT : r_crc;
        w_fb   = w_base[3] ^ i_bit;
        w_next = {w_base[2:0], 1'b0} ^ (w_fb ? POLY : 4'h0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= INIT;
        end else if (i_en) begin
            r_crc <= w_next;
        end
    end

    assign o_crc = r_crc;

endmodule : e1_crc4
`default_nettype wire

// File: rtl/e1_rx_crc4_check.sv
`default_nettype none
// ============================================================================
// Module   : e1_rx_crc4_check
// Brief    : E1 receive CRC4 verifier with E-bit latch and error counter.
// Revision : 1.0 - initial release
// ============================================================================
module e1_rx_crc4_check
    import e1_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic [3:0]       in_frame,
    input  logic [4:0]       in_ts,
    input  logic [2:0]       in_bit_pos,
    input  logic             in_mf_aligned,
    output logic             out_smf_stb,
    output logic             out_smf_idx,
    output logic             out_smf_err,
    output logic [1:0]       out_ebit,
    output logic [CNT_W-1:0] out_err_cnt,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    e1_pos_t    w_pos;
    logic       w_si;
    logic       w_first;
    logic       w_last;
    logic       w_crc_bit;
    logic [1:0] w_c_idx;
    logic [3:0] w_crc;
    logic       w_err;
    logic       w_err_stb;

    logic       r_started;
    logic       r_prev_valid;
    logic       r_end;
    logic       r_end_idx;
    logic [3:0] r_rx_c;
    logic [3:0] r_crc_prev;

    assign w_pos     = '{frame: in_frame, ts: in_ts, bit_pos: in_bit_pos};
    assign w_si      = (w_pos.ts == c_TS0) && (w_pos.bit_pos == c_BIT_FIRST) && !w_pos.frame[0];
    assign w_first   = (w_pos.frame[2:0] == 3'd0) && (w_pos.ts == c_TS0)
                       && (w_pos.bit_pos == c_BIT_FIRST);
    assign w_last    = (w_pos.frame[2:0] == c_SMF_LAST_FRAME) && (w_pos.ts == c_TS_LAST)
                       && (w_pos.bit_pos == c_BIT_LAST);
    // Si carries C bits of the previous SMF, so it contributes as zero
    assign w_crc_bit = w_si ? 1'b0 : in_bit;
    assign w_c_idx   = 2'd3 - w_pos.frame[2:1];
    assign w_err     = (r_rx_c != r_crc_prev);
    assign w_err_stb = in_mf_aligned && r_end && r_prev_valid && w_err;

    e1_crc4 #(
        .INIT (c_CRC4_INIT),
        .POLY (c_CRC4_POLY)
    ) u_crc4 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (in_valid),
        .i_first (w_first),
        .i_bit   (w_crc_bit),
        .o_crc   (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_started    <= 1'b0;
            r_prev_valid <= 1'b0;
            r_end        <= 1'b0;
            r_end_idx    <= 1'b0;
            r_rx_c       <= 4'h0;
            r_crc_prev   <= 4'h0;
            out_smf_stb  <= 1'b0;
            out_smf_idx  <= 1'b0;
            out_smf_err  <= 1'b0;
            out_ebit     <= 2'b11;
        end else begin
            out_smf_stb <= 1'b0;
            if (!in_mf_aligned) begin
                r_started    <= 1'b0;
                r_prev_valid <= 1'b0;
                r_end        <= 1'b0;
            end else begin
                r_end <= 1'b0;
                if (in_valid) begin
                    if (w_si) begin
                        r_rx_c[w_c_idx] <= in_bit;
                    end
                    if (w_first) begin
                        r_started <= 1'b1;
                    end
                    if (w_last && r_started) begin
                        r_end     <= 1'b1;
                        r_end_idx <= w_pos.frame[3];
                    end
                end
                // CRC register holds the finished SMF remainder in this cycle
                if (r_end) begin
                    r_crc_prev   <= w_crc;
                    r_prev_valid <= 1'b1;
                    if (r_prev_valid) begin
                        out_smf_stb           <= 1'b1;
                        out_smf_idx           <= r_end_idx;
                        out_smf_err           <= w_err;
                        out_ebit[r_end_idx]   <= ~w_err;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_err_cnt <= '0;
        end else if (cnt_clr) begin
            out_err_cnt <= w_err_stb ? c_CNT_ONE : '0;
        end else if (w_err_stb && (out_err_cnt != c_CNT_MAX)) begin
            out_err_cnt <= out_err_cnt + c_CNT_ONE;
        end
    end

endmodule : e1_rx_crc4_check
`default_nettype wire

// File: tb/tb_e1_rx_crc4_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_e1_rx_crc4_check
// Brief    : Randomised bench for e1_rx_crc4_check against a division model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e1_rx_crc4_check;

    typedef struct packed {
        logic       idx;
        logic       err;
        logic [1:0] ebit;
        logic [9:0] cnt;
        logic [1:0] cnt2;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_frame = 4'd0;
    logic [4:0] in_ts = 5'd0;
    logic [2:0] in_bit_pos = 3'd0;
    logic       in_mf_aligned = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       out_smf_stb, out_smf_idx, out_smf_err;
    logic [1:0] out_ebit;
    logic [9:0] out_err_cnt;
    logic       d2_stb, d2_idx, d2_err;
    logic [1:0] d2_ebit;
    logic [1:0] d2_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit         smf_bits [0:2047];
    rec_t       exp_q[$];
    rec_t       got_q[$];
    logic [3:0] gen_prev_crc;
    logic [3:0] m_prev_crc;
    bit         m_prev_valid;
    logic [1:0] m_ebit;
    int         m_cnt, m_cnt2;
    logic [1:0] snap_ebit;
    logic [9:0] snap_cnt;
    logic       snap_stb;

    always #5 clk = ~clk;

    e1_rx_crc4_check #(.CNT_W(10)) u_dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_frame(in_frame), .in_ts(in_ts), .in_bit_pos(in_bit_pos),
        .in_mf_aligned(in_mf_aligned), .out_smf_stb(out_smf_stb),
        .out_smf_idx(out_smf_idx), .out_smf_err(out_smf_err),
        .out_ebit(out_ebit), .out_err_cnt(out_err_cnt), .cnt_clr(cnt_clr)
    );

    e1_rx_crc4_check #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_frame(in_frame), .in_ts(in_ts), .in_bit_pos(in_bit_pos),
        .in_mf_aligned(in_mf_aligned), .out_smf_stb(d2_stb),
        .out_smf_idx(d2_idx), .out_smf_err(d2_err),
        .out_ebit(d2_ebit), .out_err_cnt(d2_cnt), .cnt_clr(cnt_clr)
    );

    always @(negedge clk) begin
        if (out_smf_stb) begin
            got_q.push_back('{idx: out_smf_idx, err: out_smf_err, ebit: out_ebit,
                              cnt: out_err_cnt, cnt2: d2_cnt});
        end
    end

    // Remainder of M(x)*x^4 divided by x^4+x+1, Si positions zeroed
    function automatic logic [3:0] model_crc();
        bit a [0:2051];
        for (int i = 0; i < 2052; i++) begin
            a[i] = (i < 2048) ? smf_bits[i] : 1'b0;
        end
        for (int f = 0; f < 8; f += 2) a[f*256] = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            if (a[i]) begin
                a[i]   = ~a[i];
                a[i+3] = ~a[i+3];
                a[i+4] = ~a[i+4];
            end
        end
        return {a[2048], a[2049], a[2050], a[2051]};
    endfunction

    task automatic model_reset();
        m_prev_valid = 1'b0;
        m_ebit       = 2'b11;
        m_cnt        = 0;
        m_cnt2       = 0;
    endtask

    task automatic send_smf(input bit half, input bit rnd, input bit invc, input bit flip,
                            input int gap_pct, input int drop_lo, input int drop_hi,
                            input int rst_frame, input bit clr_end);
        logic [3:0] c_tx, golden, actual;
        bit         complete, err;
        c_tx = invc ? ~gen_prev_crc : gen_prev_crc;
        for (int k = 0; k < 2048; k++) smf_bits[k] = rnd ? 1'($urandom) : 1'b0;
        for (int f = 0; f < 8; f += 2) smf_bits[f*256] = c_tx[3 - f/2];
        golden = model_crc();
        gen_prev_crc = golden;
        if (flip) smf_bits[256 + 8] = ~smf_bits[256 + 8];
        actual = model_crc();
        complete = (drop_lo < 0) && (rst_frame < 0);

        for (int k = 0; k < 2048; k++) begin
            int f;
            f = k / 256;
            if (rst_frame >= 0 && k == rst_frame * 256) begin
                @(posedge clk); #1;
                in_valid = 1'b0; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                snap_stb = out_smf_stb; snap_ebit = out_ebit; snap_cnt = out_err_cnt;
                model_reset();
            end
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_bit = 1'($urandom);
            end
            @(posedge clk); #1;
            in_valid      = 1'b1;
            in_bit        = smf_bits[k];
            in_frame      = {half, 3'(f)};
            in_ts         = 5'((k / 8) % 32);
            in_bit_pos    = 3'(k % 8);
            in_mf_aligned = !(f >= drop_lo && f <= drop_hi);
        end
        if (clr_end) begin
            @(posedge clk); #1;
            in_valid = 1'b0; cnt_clr = 1'b1;
            @(posedge clk); #1;
            cnt_clr = 1'b0;
        end

        if (complete) begin
            if (m_prev_valid) begin
                err = (c_tx != m_prev_crc);
                m_ebit[half] = ~err;
                if (clr_end) begin
                    m_cnt  = err ? 1 : 0;
                    m_cnt2 = err ? 1 : 0;
                end else if (err) begin
                    if (m_cnt < 1023) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
                exp_q.push_back('{idx: half, err: err, ebit: m_ebit,
                                  cnt: 10'(m_cnt), cnt2: 2'(m_cnt2)});
            end
            m_prev_crc   = actual;
            m_prev_valid = 1'b1;
        end else begin
            m_prev_valid = 1'b0;
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        gen_prev_crc = 4'h0;
        n_cmp++;
        if ({out_smf_stb, out_smf_idx, out_smf_err, out_ebit, out_err_cnt, d2_cnt}
            !== {1'b0, 1'b0, 1'b0, 2'b11, 10'd0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset: stb=%b idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d, want 0 0 0 11 0 0",
                     out_smf_stb, out_smf_idx, out_smf_err, out_ebit, out_err_cnt, d2_cnt);
        end
    endtask

    task automatic test_zero_payload();
        for (int s = 0; s < 4; s++) send_smf(1'(s), 0, 0, 0, 0, -1, -1, -1, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 3) begin
            n_bad++;
            $display("FAIL zero_count: strobes=%0d want 3", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL zero_strobe: got idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d want idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d",
                         g.idx, g.err, g.ebit, g.cnt, g.cnt2, e.idx, e.err, e.ebit, e.cnt, e.cnt2);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_flip();
        for (int s = 0; s < 4; s++) send_smf(1'(s), 0, 0, (s == 0), 0, -1, -1, -1, 0);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL flip_count: strobes=%0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL flip_strobe: got idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d want idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d",
                         g.idx, g.err, g.ebit, g.cnt, g.cnt2, e.idx, e.err, e.ebit, e.cnt, e.cnt2);
            end
        end
        got_q.delete(); exp_q.delete();
        n_cmp++;
        if (out_err_cnt !== 10'd1 || out_ebit !== 2'b11) begin
            n_bad++;
            $display("FAIL flip_final: cnt=%0d ebit=%b want 1 11", out_err_cnt, out_ebit);
        end
    endtask

    task automatic test_random_gaps();
        for (int s = 0; s < 10; s++) send_smf(1'(s), 1, 0, 0, 10, -1, -1, -1, 0);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: strobes=%0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL random_strobe: got idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d want idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d",
                         g.idx, g.err, g.ebit, g.cnt, g.cnt2, e.idx, e.err, e.ebit, e.cnt, e.cnt2);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_align_loss();
        logic [9:0] cnt_before;
        cnt_before = out_err_cnt;
        send_smf(1'b0, 1, 0, 0, 5, 3, 5, -1, 0);
        send_smf(1'b1, 1, 0, 0, 5, -1, -1, -1, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL align_quiet: strobes=%0d want 0", got_q.size());
        end
        got_q.delete();
        send_smf(1'b0, 1, 0, 0, 5, -1, -1, -1, 0);
        send_smf(1'b1, 1, 0, 0, 5, -1, -1, -1, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            n_bad++;
            $display("FAIL align_resume: strobes=%0d want 2 (model %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL align_strobe: got idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d want idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d",
                         g.idx, g.err, g.ebit, g.cnt, g.cnt2, e.idx, e.err, e.ebit, e.cnt, e.cnt2);
            end
        end
        got_q.delete(); exp_q.delete();
        n_cmp++;
        if (out_err_cnt !== cnt_before) begin
            n_bad++;
            $display("FAIL align_cnt: cnt=%0d want %0d", out_err_cnt, cnt_before);
        end
    endtask

    task automatic test_saturate();
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        m_cnt = 0; m_cnt2 = 0;
        n_cmp++;
        if (out_err_cnt !== 10'd0 || d2_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL clr_alone: cnt=%0d cnt2=%0d want 0 0", out_err_cnt, d2_cnt);
        end
        for (int s = 0; s < 5; s++) send_smf(1'(s), 1, 1, 0, 0, -1, -1, -1, (s == 4));
        drain();
        n_cmp++;
        if (got_q.size() != 5) begin
            n_bad++;
            $display("FAIL sat_count: strobes=%0d want 5", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL sat_strobe: got idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d want idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d",
                         g.idx, g.err, g.ebit, g.cnt, g.cnt2, e.idx, e.err, e.ebit, e.cnt, e.cnt2);
            end
        end
        got_q.delete(); exp_q.delete();
        n_cmp++;
        if (d2_cnt !== 2'd1 || out_err_cnt !== 10'd1) begin
            n_bad++;
            $display("FAIL clr_with_err: cnt=%0d cnt2=%0d want 1 1", out_err_cnt, d2_cnt);
        end
    endtask

    task automatic test_mid_reset();
        send_smf(1'b0, 1, 0, 0, 0, -1, -1, 4, 0);
        n_cmp++;
        if (snap_stb !== 1'b0 || snap_ebit !== 2'b11 || snap_cnt !== 10'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state: stb=%b ebit=%b cnt=%0d want 0 11 0",
                     snap_stb, snap_ebit, snap_cnt);
        end
        send_smf(1'b1, 1, 0, 0, 0, -1, -1, -1, 0);
        send_smf(1'b0, 1, 0, 0, 0, -1, -1, -1, 0);
        send_smf(1'b1, 1, 0, 0, 0, -1, -1, -1, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL mid_reset_count: strobes=%0d want 2", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL mid_reset_strobe: got idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d want idx=%b err=%b ebit=%b cnt=%0d cnt2=%0d",
                         g.idx, g.err, g.ebit, g.cnt, g.cnt2, e.idx, e.err, e.ebit, e.cnt, e.cnt2);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_zero_payload();
        test_flip();
        test_random_gaps();
        test_align_loss();
        test_saturate();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_e1_rx_crc4_check
`default_nettype wire
